// File: rtl/clint_timer_ctrl.sv
// Machine timer block: free-running mtime with prescaler, MMIO-mapped mtime/mtimecmp,
// CSR-path time writes and registered MTIP/STIP generation.
module clint_timer_ctrl #(
    parameter int unsigned TICK_DIV = 10,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    input  logic              csr_time_we,
    input  logic [63:0]       csr_time_wdata,
    input  logic [63:0]       mcountinhibit,
    input  logic [63:0]       stimecmp,
    input  logic              menvcfg_stce,
    output logic [63:0]       time_rdata,
    output logic              mip_mtip,
    output logic              mip_stip
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {StIdle, StResp} state_e;

    state_e          state_q;
    logic [63:0]     mtime_q, mtime_d;
    logic [63:0]     mtimecmp_q;
    logic [PW-1:0]   presc_q, presc_d;

    logic [ADDR_W-4:0] word_idx;
    logic              sel_mtime, sel_cmp;
    logic              tm, tick, stall, accept, mmio_time_we;
    logic              unused_bits;

    // Addresses are decoded on 8-byte words; the byte offset within a word is ignored.
    assign word_idx  = req_addr[ADDR_W-1:3];
    assign sel_mtime = (word_idx == '0);
    assign sel_cmp   = (word_idx == (ADDR_W-3)'(1));
    assign unused_bits = ^{mcountinhibit[63:2], mcountinhibit[0], req_addr[2:0]};

    assign tm   = mcountinhibit[1];
    assign tick = ~tm & (presc_q == PW'(TICK_DIV - 1));

    // A CSR time write wins over an MMIO mtime write, so the MMIO side is stalled.
    assign stall        = csr_time_we & req_valid & req_we & sel_mtime;
    assign req_ready    = ~rst & (state_q == StIdle) & ~stall;
    assign accept       = req_valid & req_ready;
    assign mmio_time_we = accept & req_we & sel_mtime;

    assign time_rdata = mtime_q;

    // Next mtime/prescaler: CSR write > MMIO write > tick > hold.
    always_comb begin
        mtime_d = mtime_q;
        presc_d = presc_q;
        if (csr_time_we) begin
            mtime_d = csr_time_wdata;
            presc_d = '0;
        end else if (mmio_time_we) begin
            mtime_d = req_wdata;
            presc_d = '0;
        end else if (!tm) begin
            if (tick) begin
                mtime_d = mtime_q + 64'd1;
                presc_d = '0;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // Timer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime_q <= '0;
            presc_q <= '0;
        end else begin
            mtime_q <= mtime_d;
            presc_q <= presc_d;
        end
    end

    // MMIO request FSM with registered response and mtimecmp write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            mtimecmp_q <= '1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q    <= StResp;
                        resp_valid <= 1'b1;
                        resp_err   <= ~(sel_mtime | sel_cmp);
                        resp_rdata <= '0;
                        if (!req_we) begin
                            // Reads return the value held before this cycle's update.
                            if (sel_mtime) resp_rdata <= mtime_q;
                            else if (sel_cmp) resp_rdata <= mtimecmp_q;
                        end else if (sel_cmp) begin
                            mtimecmp_q <= req_wdata;
                        end
                    end
                end
                StResp: begin
                    state_q    <= StIdle;
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Level interrupt flags, one cycle behind the compared state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mip_mtip <= 1'b0;
            mip_stip <= 1'b0;
        end else begin
            mip_mtip <= (mtime_q >= mtimecmp_q);
            mip_stip <= menvcfg_stce & (mtime_q >= stimecmp);
        end
    end

endmodule

// File: tb/tb_clint_timer_ctrl.sv
// Randomized scoreboard bench for clint_timer_ctrl against a time-as-arithmetic model.
module tb_clint_timer_ctrl;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned ADDR_W   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [63:0]       req_wdata = '0;
    logic              resp_valid;
    logic [63:0]       resp_rdata;
    logic              resp_err;
    logic              csr_time_we = 1'b0;
    logic [63:0]       csr_time_wdata = '0;
    logic [63:0]       mcountinhibit = '0;
    logic [63:0]       stimecmp = '1;
    logic              menvcfg_stce = 1'b0;
    logic [63:0]       time_rdata;
    logic              mip_mtip;
    logic              mip_stip;

    int n_vec = 0;
    int n_bad = 0;

    clint_timer_ctrl #(.TICK_DIV(TICK_DIV), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .csr_time_we(csr_time_we), .csr_time_wdata(csr_time_wdata),
        .mcountinhibit(mcountinhibit), .stimecmp(stimecmp), .menvcfg_stce(menvcfg_stce),
        .time_rdata(time_rdata), .mip_mtip(mip_mtip), .mip_stip(mip_stip)
    );

    always #5 clk = ~clk;

    // Model: mtime = last written value + (uninhibited cycles since then) / TICK_DIV.
    logic [63:0]     m_base = '0;
    longint unsigned m_active = 0;
    logic [63:0]     m_cmp = '1;
    bit              m_busy = 0;
    bit              e_mtip = 0;
    bit              e_stip = 0;
    logic [64:0]     exp_q[$];   // {err, rdata}

    function automatic logic [63:0] m_time();
        return m_base + 64'(m_active / TICK_DIV);
    endfunction

    function automatic int m_word(input logic [ADDR_W-1:0] a);
        return int'(a >> 3);
    endfunction

    function automatic bit m_ready();
        return !rst && !m_busy && !(csr_time_we && req_valid && req_we && m_word(req_addr) == 0);
    endfunction

    always @(posedge clk) begin : model
        logic [63:0] now;
        bit          acc;
        logic [63:0] rd;
        if (rst) begin
            m_base = '0; m_active = 0; m_cmp = '1; m_busy = 0;
            e_mtip = 0; e_stip = 0;
            exp_q.delete();
        end else begin
            now = m_time();
            acc = m_ready() && req_valid;
            e_mtip = (now >= m_cmp);
            e_stip = menvcfg_stce && (now >= stimecmp);
            if (acc) begin
                rd = '0;
                if (!req_we && m_word(req_addr) == 0) rd = now;
                if (!req_we && m_word(req_addr) == 1) rd = m_cmp;
                exp_q.push_back({m_word(req_addr) > 1, rd});
            end
            if (csr_time_we) begin
                m_base = csr_time_wdata; m_active = 0;
            end else if (acc && req_we && m_word(req_addr) == 0) begin
                m_base = req_wdata; m_active = 0;
            end else if (!mcountinhibit[1]) begin
                m_active++;
            end
            if (acc && req_we && m_word(req_addr) == 1) m_cmp = req_wdata;
            m_busy = m_busy ? 0 : acc;
        end
    end

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle state outputs plus scoreboard pop on each response pulse.
    always @(posedge clk) begin : monitor
        logic [64:0] e;
        #1;
        chk64("time_rdata", time_rdata, m_time());
        chk64("mip_mtip", 64'(mip_mtip), 64'(e_mtip));
        chk64("mip_stip", 64'(mip_stip), 64'(e_stip));
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                chk64("unexpected_resp", 64'(resp_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk64("resp_rdata", resp_rdata, e[63:0]);
                chk64("resp_err", 64'(resp_err), 64'(e[64]));
            end
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk64("missing_resp", 64'(resp_valid), 64'd1);
        end
    end

    task automatic step(input logic v, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [63:0] wd, input logic cw, input logic [63:0] cwd);
        @(negedge clk);
        req_valid = v; req_we = we; req_addr = a; req_wdata = wd;
        csr_time_we = cw; csr_time_wdata = cwd;
        #1;
        chk64("req_ready", 64'(req_ready), 64'(m_ready()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    // Single request followed by an idle cycle so it never meets the busy window.
    task automatic req(input logic we, input logic [ADDR_W-1:0] a, input logic [63:0] wd);
        step(1'b1, we, a, wd, 1'b0, '0);
        idle(1);
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        logic [63:0]       wd;
        int                r;
        repeat (2) @(negedge clk);
        #2;
        chk64("reset_ready", 64'(req_ready), 64'd0);
        chk64("reset_resp_valid", 64'(resp_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        chk64("time_after_40", time_rdata, 64'd10);
        chk64("mtip_after_40", 64'(mip_mtip), 64'd0);

        // Compare crossing, then raise compare to clear.
        req(1'b1, 16'h0008, m_time() + 64'd2);
        idle(14);
        chk64("mtip_set", 64'(mip_mtip), 64'd1);
        req(1'b1, 16'h0008, 64'd100);
        idle(1);
        chk64("mtip_clear", 64'(mip_mtip), 64'd0);
        req(1'b0, 16'h0008, '0);

        // CSR write collides with MMIO mtime write.
        step(1'b1, 1'b1, 16'h0000, 64'h2000, 1'b1, 64'h1000);
        step(1'b1, 1'b1, 16'h0000, 64'h2000, 1'b0, '0);
        idle(1);
        chk64("collide_time", time_rdata, 64'h2000);
        req(1'b0, 16'h0000, '0);

        // Inhibit freezes mtime and the prescaler.
        idle(2);
        mcountinhibit = 64'd2;
        idle(20);
        mcountinhibit = '0;
        idle(6);

        // Supervisor timer gating by STCE.
        stimecmp = '0;
        idle(3);
        menvcfg_stce = 1'b1;
        idle(3);
        menvcfg_stce = 1'b0;

        // Unmapped address and wrap of mtime.
        req(1'b0, 16'h0010, '0);
        req(1'b1, 16'h0018, 64'h55);
        step(1'b0, 1'b0, '0, '0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        idle(10);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            if ($urandom_range(0, 19) == 0) mcountinhibit = {62'd0, ~mcountinhibit[1], 1'b0};
            if ($urandom_range(0, 15) == 0) stimecmp = m_time() + 64'($urandom_range(0, 30));
            if ($urandom_range(0, 15) == 0) menvcfg_stce = ~menvcfg_stce;
            r = $urandom_range(0, 7);
            if (r < 3) a = 16'h0000;
            else if (r < 6) a = 16'h0008;
            else if (r == 6) a = ($urandom_range(0, 1) != 0) ? 16'h0010 : 16'h0018;
            else a = 16'($urandom) & 16'hFFF8;
            if ($urandom_range(0, 9) == 0) wd = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
            else wd = m_time() + 64'($urandom_range(0, 48)) - 64'd8;
            step($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, a, wd,
                 $urandom_range(0, 15) == 0, m_time() + 64'($urandom_range(0, 64)));
        end
        idle(4);
        chk64("drain_queue", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
